// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_pkg
//  Description : Shared constants and helpers for the multi-port register
//                file and its busy scoreboard.
//                Provides default geometry constants and the legal-address
//                predicate used by writes, allocs and reads alike.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

    localparam int c_DATA_W   = 32;
    localparam int c_ADDR_W   = 5;
    localparam int c_NUM_REGS = 32;
    localparam int c_NUM_RD   = 2;

    // An address is legal when it names an implemented register and is not
    // the hard-wired zero register. Illegal writes/allocs are dropped and
    // illegal reads return zero / not-busy.
    function automatic logic addr_legal(
        input logic [31:0] addr,
        input int          num_regs,
        input bit          zero_reg
    );
        return (addr < 32'(num_regs)) && !(zero_reg && (addr == 32'd0));
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_scoreboard
//  Description : Per-register busy bits for pipeline hazard detection.
//                Alloc sets a bit, writeback clears it; when both target the
//                same register in one cycle the alloc wins because a newer
//                producer is now in flight.
//  Ports       : clk, reset (async, active-low)
//                clr_en/clr_addr     - writeback clear request
//                alloc_en/alloc_addr - decode allocation request
//                busy_vec            - scoreboard, straight from flops
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W   = c_ADDR_W,
    parameter int NUM_REGS = c_NUM_REGS,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr_en,
    input  logic [ADDR_W-1:0]   clr_addr,
    input  logic                alloc_en,
    input  logic [ADDR_W-1:0]   alloc_addr,
    output logic [NUM_REGS-1:0] busy_vec
);

    logic                w_clr_ok;
    logic                w_alloc_ok;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic [NUM_REGS-1:0] r_busy;

    assign w_clr_ok   = clr_en   && addr_legal(32'(clr_addr),   NUM_REGS, ZERO_REG);
    assign w_alloc_ok = alloc_en && addr_legal(32'(alloc_addr), NUM_REGS, ZERO_REG);

    always_comb begin
        w_busy_nxt = r_busy;
        for (int r = 0; r < NUM_REGS; r++) begin
            // Alloc is checked first so it overrides a same-cycle clear.
            if (w_alloc_ok && (alloc_addr == ADDR_W'(r))) begin
                w_busy_nxt[r] = 1'b1;
            end else if (w_clr_ok && (clr_addr == ADDR_W'(r))) begin
                w_busy_nxt[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy_vec = r_busy;

endmodule
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_mp
//  Description : General-purpose register bank with NUM_RD registered read
//                ports, same-cycle write-to-read bypass and a busy scoreboard.
//  Ports       : clk, reset (async, active-low)
//                rd_en[NUM_RD], rd_addr[NUM_RD*ADDR_W]  - read requests
//                rd_data[NUM_RD*DATA_W], rd_busy[NUM_RD] - registered results
//                we, wr_addr, wr_data                    - writeback
//                alloc_en, alloc_addr                    - destination alloc
//                busy_vec[NUM_REGS]                      - live scoreboard
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = c_DATA_W,
    parameter int ADDR_W   = c_ADDR_W,
    parameter int NUM_REGS = c_NUM_REGS,
    parameter int NUM_RD   = c_NUM_RD,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_addr,
    output logic [NUM_REGS-1:0]      busy_vec
);

    logic              w_wr_ok;
    logic [DATA_W-1:0] r_regs [NUM_REGS];

    assign w_wr_ok = we && addr_legal(32'(wr_addr), NUM_REGS, ZERO_REG);

    // ------------------------------------------------------------------
    // Data array. Register 0 under ZERO_REG is never written because the
    // legality check rejects it, so it stays at its reset value of zero.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w_wr_ok && (wr_addr == ADDR_W'(r))) begin
                    r_regs[r] <= wr_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Busy scoreboard: a legal write clears, a legal alloc sets.
    // ------------------------------------------------------------------
    reg_file_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .clr_en     (we),
        .clr_addr   (wr_addr),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .busy_vec   (busy_vec)
    );

    // ------------------------------------------------------------------
    // Read ports. Each port captures at the edge; rd_en=0 holds the last
    // result. The scoreboard is read pre-update, so a same-cycle alloc is
    // not seen, while a same-cycle legal write both forwards its data and
    // reports the register as no longer busy.
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic              w_legal;
        logic              w_bypass;
        logic [DATA_W-1:0] w_arr_data;
        logic              w_arr_busy;
        logic [DATA_W-1:0] w_data_nxt;
        logic              w_busy_nxt;
        logic [DATA_W-1:0] r_rd_data;
        logic              r_rd_busy;

        assign w_addr   = rd_addr[p*ADDR_W +: ADDR_W];
        assign w_legal  = addr_legal(32'(w_addr), NUM_REGS, ZERO_REG);
        assign w_bypass = w_wr_ok && (wr_addr == w_addr);

        // Compare-based mux keeps out-of-range addresses from indexing
        // past the end of the array.
        always_comb begin
            w_arr_data = '0;
            w_arr_busy = 1'b0;
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w_addr == ADDR_W'(r)) begin
                    w_arr_data = r_regs[r];
                    w_arr_busy = busy_vec[r];
                end
            end
        end

        always_comb begin
            w_data_nxt = '0;
            w_busy_nxt = 1'b0;
            if (w_legal) begin
                w_data_nxt = w_bypass ? wr_data : w_arr_data;
                w_busy_nxt = w_arr_busy && !w_bypass;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_rd_data <= '0;
                r_rd_busy <= 1'b0;
            end else if (rd_en[p]) begin
                r_rd_data <= w_data_nxt;
                r_rd_busy <= w_busy_nxt;
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = r_rd_data;
        assign rd_busy[p]                  = r_rd_busy;
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file_mp
//  Description : Self-checking bench for reg_file_mp in a 4-port, 64-bit,
//                24-register configuration with the zero register enabled.
//                A behavioural array model predicts every output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_mp;

    localparam int DW  = 64;
    localparam int AW  = 5;
    localparam int NR  = 24;
    localparam int NRD = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NRD-1:0]    rd_en;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_busy;
    logic              we;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              alloc_en;
    logic [AW-1:0]     alloc_addr;
    logic [NR-1:0]     busy_vec;

    always #5 clk = ~clk;

    reg_file_mp #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_REGS (NR),
        .NUM_RD   (NRD),
        .ZERO_REG (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .we         (we),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .busy_vec   (busy_vec)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: register contents, busy set, expected port outputs.
    logic [DW-1:0] m_reg  [NR];
    logic [NR-1:0] m_busy;
    logic [DW-1:0] e_data [NRD];
    logic          e_busy [NRD];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input int a);
        return (a > 0) && (a < NR);
    endfunction

    function automatic logic [DW-1:0] port_data(input int p);
        return rd_data[p*DW +: DW];
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++) m_reg[r] = '0;
        m_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            e_data[p] = '0;
            e_busy[p] = 1'b0;
        end
    endtask

    task automatic idle();
        rd_en    = '0;
        we       = 1'b0;
        alloc_en = 1'b0;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_en[p]           = 1'b1;
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic check_all_zero(input string tag);
        for (int p = 0; p < NRD; p++) begin
            check($sformatf("%s_data%0d", tag, p), port_data(p), '0);
            check($sformatf("%s_busy%0d", tag, p), DW'(rd_busy[p]), '0);
        end
        check($sformatf("%s_busy_vec", tag), DW'(busy_vec), '0);
    endtask

    // Predict, clock one edge, compare all outputs against the model.
    task automatic cycle();
        int a;
        int wa;
        int aa;
        wa = int'(wr_addr);
        aa = int'(alloc_addr);
        for (int p = 0; p < NRD; p++) begin
            if (rd_en[p]) begin
                a = int'(rd_addr[p*AW +: AW]);
                if (!legal(a)) begin
                    e_data[p] = '0;
                    e_busy[p] = 1'b0;
                end else if (we && legal(wa) && wa == a) begin
                    e_data[p] = wr_data;
                    e_busy[p] = 1'b0;
                end else begin
                    e_data[p] = m_reg[a];
                    e_busy[p] = m_busy[a];
                end
            end
        end
        if (we && legal(wa)) begin
            m_reg[wa]  = wr_data;
            m_busy[wa] = 1'b0;
        end
        if (alloc_en && legal(aa)) m_busy[aa] = 1'b1;
        @(posedge clk);
        #1;
        for (int p = 0; p < NRD; p++) begin
            check($sformatf("rd_data%0d", p), port_data(p), e_data[p]);
            check($sformatf("rd_busy%0d", p), DW'(rd_busy[p]), DW'(e_busy[p]));
        end
        check("busy_vec", DW'(busy_vec), DW'(m_busy));
    endtask

    // Called at posedge+1: pulse reset between edges, check it acts at once.
    task automatic mid_reset();
        #1;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset      = 1'b0;
        rd_en      = '0;
        rd_addr    = '0;
        we         = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        alloc_en   = 1'b0;
        alloc_addr = '0;
        model_reset();
        #12;
        check_all_zero("reset");
        reset = 1'b1;

        // Reset wipes a written register.
        @(posedge clk); #1;
        idle(); we = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEADBEEF;
        cycle();
        idle(); set_rd(0, 5); cycle();
        check("r5_written", port_data(0), 64'hDEADBEEF);
        mid_reset();
        idle(); set_rd(0, 5); cycle();
        check("r5_after_reset", port_data(0), '0);

        // Bypass, then storage on another port.
        idle(); we = 1'b1; wr_addr = 5'd7; wr_data = 64'h12345678; set_rd(0, 7);
        cycle();
        check("bypass_p0", port_data(0), 64'h12345678);
        idle(); set_rd(1, 7); cycle();
        check("stored_p1", port_data(1), 64'h12345678);

        // Zero register.
        idle(); we = 1'b1; wr_addr = 5'd0; wr_data = 64'hFFFFFFFF; set_rd(0, 0); set_rd(1, 0);
        cycle();
        idle(); set_rd(0, 0); set_rd(1, 0); cycle();
        check("r0_p0", port_data(0), '0);
        check("r0_p1", port_data(1), '0);
        idle(); alloc_en = 1'b1; alloc_addr = 5'd0; cycle();
        check("r0_not_busy", DW'(busy_vec[0]), '0);

        // Scoreboard sequence on r3.
        idle(); alloc_en = 1'b1; alloc_addr = 5'd3; cycle();
        check("alloc_r3", DW'(busy_vec[3]), 64'd1);
        idle(); set_rd(0, 3); cycle();
        check("rd_busy_r3", DW'(rd_busy[0]), 64'd1);
        idle(); we = 1'b1; wr_addr = 5'd3; wr_data = 64'hA5; set_rd(0, 3); cycle();
        check("wr_rd_busy_r3", DW'(rd_busy[0]), '0);
        check("wr_rd_data_r3", port_data(0), 64'hA5);
        idle(); we = 1'b1; wr_addr = 5'd3; wr_data = 64'h5A; alloc_en = 1'b1; alloc_addr = 5'd3;
        cycle();
        check("wr_alloc_r3", DW'(busy_vec[3]), 64'd1);

        // Hold while r2 changes.
        idle(); we = 1'b1; wr_addr = 5'd2; wr_data = 64'h1111; cycle();
        idle(); set_rd(2, 2); cycle();
        for (int k = 0; k < 3; k++) begin
            idle(); we = 1'b1; wr_addr = 5'd2; wr_data = 64'(k + 64'h2222); cycle();
            check("hold_p2", port_data(2), 64'h1111);
        end

        // Out-of-range register 30.
        idle(); we = 1'b1; wr_addr = 5'd30; wr_data = 64'hBAD; alloc_en = 1'b1; alloc_addr = 5'd30;
        set_rd(3, 30); cycle();
        check("r30_bypass", port_data(3), '0);
        idle(); set_rd(3, 30); cycle();
        check("r30_read", port_data(3), '0);

        // Four ports, four distinct 64-bit patterns.
        for (int p = 0; p < NRD; p++) begin
            idle(); we = 1'b1; wr_addr = AW'(10 + p);
            wr_data = {32'hC0DE0000 | 32'(p), 32'h89ABCDEF ^ 32'(p << 8)};
            cycle();
        end
        idle();
        for (int p = 0; p < NRD; p++) set_rd(p, 10 + p);
        cycle();
        for (int p = 0; p < NRD; p++)
            check($sformatf("multi_p%0d", p), port_data(p),
                  {32'hC0DE0000 | 32'(p), 32'h89ABCDEF ^ 32'(p << 8)});

        // Randomized traffic, with occasional asynchronous resets.
        for (int n = 0; n < 3000; n++) begin
            rd_en = NRD'($urandom);
            for (int p = 0; p < NRD; p++)
                rd_addr[p*AW +: AW] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7))
                                                                  : AW'($urandom_range(0, 31));
            we         = ($urandom_range(0, 1) != 0);
            wr_addr    = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
            wr_data    = {$urandom, $urandom};
            alloc_en   = ($urandom_range(0, 2) == 0);
            alloc_addr = AW'($urandom_range(0, 7));
            cycle();
            if (n % 700 == 699) mid_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
